// File: rtl/ram_sort_pkg.sv
// ============================================================================
// Module   : ram_sort_pkg
// Brief    : Shared constants and FSM state encoding for the RAM bubble sorter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_sort_pkg;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int DW      = 8;
  localparam int NUM_CMP = DEPTH * (DEPTH - 1) / 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    CMP  = 3'd3,
    WR_A = 3'd4,
    WR_B = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_bus_drv.sv
// ============================================================================
// Module   : ram_bus_drv
// Brief    : Tristate driver for the shared RAM data bus plus read-capture regs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bus_drv #(
  parameter int DW = ram_sort_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          cap_a,
  input  logic          cap_b,
  inout  wire  [DW-1:0] data,
  output logic [DW-1:0] a_q,
  output logic [DW-1:0] b_q
);

  // The sorter only owns the bus while writing; otherwise the RAM drives it.
  assign data = wr ? {DW{1'bz}} : wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (cap_a) a_q <= data;
      if (cap_b) b_q <= data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_sorter.sv
// ============================================================================
// Module   : ram_sorter
// Brief    : In-place ascending bubble sort of a single-port RAM over a shared
//            bidirectional bus. Define RAM_SORT_EARLY_EXIT_EN to stop after a
//            pass that performed no swaps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sorter #(
  parameter int DEPTH = ram_sort_pkg::DEPTH,
  parameter int AW    = ram_sort_pkg::AW,
  parameter int DW    = ram_sort_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] add,
  output logic          wr,
  inout  wire  [DW-1:0] data,
  output logic          busy,
  output logic          done,
  output logic [7:0]    swap_cnt
);

  import ram_sort_pkg::*;

  localparam logic [AW-1:0] c_last_pass = AW'(DEPTH - 2);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_j;
  logic [AW-1:0] r_pass;
  logic [AW-1:0] w_j_inc;
  logic [AW-1:0] w_last_j;
  logic [DW-1:0] w_a_q;
  logic [DW-1:0] w_b_q;
  logic [DW-1:0] w_wdata;
  logic          w_cap_a;
  logic          w_cap_b;
  logic          w_gt;
  logic          w_end_pass;
  logic          w_finish;
  logic          w_advance;

  assign w_j_inc    = r_j + AW'(1);
  assign w_last_j   = c_last_pass - r_pass;
  assign w_end_pass = (r_j == w_last_j);
  assign w_gt       = (w_a_q > w_b_q);
  assign w_advance  = ((r_state == CMP) && !w_gt) || (r_state == WR_B);

`ifdef RAM_SORT_EARLY_EXIT_EN
  logic r_swapped;
  // A swap in WR_B belongs to the current pass even before r_swapped updates.
  assign w_finish = w_end_pass &&
                    ((r_pass == c_last_pass) || !(r_swapped || (r_state == WR_B)));
`else
  assign w_finish = w_end_pass && (r_pass == c_last_pass);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RD_A;
      RD_A:    w_next = RD_B;
      RD_B:    w_next = CMP;
      CMP:     w_next = w_gt ? WR_A : (w_finish ? DONE : RD_A);
      WR_A:    w_next = WR_B;
      WR_B:    w_next = w_finish ? DONE : RD_A;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    add     = '0;
    wr      = 1'b1;
    w_wdata = '0;
    busy    = 1'b0;
    done    = 1'b0;
    w_cap_a = 1'b0;
    w_cap_b = 1'b0;
    case (r_state)
      RD_A: begin add = r_j;     busy = 1'b1; w_cap_a = 1'b1; end
      RD_B: begin add = w_j_inc; busy = 1'b1; w_cap_b = 1'b1; end
      CMP:  begin add = r_j;     busy = 1'b1; end
      WR_A: begin add = r_j;     busy = 1'b1; wr = 1'b0; w_wdata = w_b_q; end
      WR_B: begin add = w_j_inc; busy = 1'b1; wr = 1'b0; w_wdata = w_a_q; end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_j      <= '0;
      r_pass   <= '0;
      swap_cnt <= '0;
`ifdef RAM_SORT_EARLY_EXIT_EN
      r_swapped <= 1'b0;
`endif
    end else begin
      if ((r_state == IDLE) && start) begin
        r_j      <= '0;
        r_pass   <= '0;
        swap_cnt <= '0;
`ifdef RAM_SORT_EARLY_EXIT_EN
        r_swapped <= 1'b0;
`endif
      end
      if (r_state == WR_B) begin
        if (swap_cnt != 8'hFF) swap_cnt <= swap_cnt + 8'd1;
`ifdef RAM_SORT_EARLY_EXIT_EN
        r_swapped <= 1'b1;
`endif
      end
      // Later assignments win, so a new pass clears the swap flag set above.
      if (w_advance && !w_finish) begin
        if (!w_end_pass) begin
          r_j <= w_j_inc;
        end else begin
          r_j    <= '0;
          r_pass <= r_pass + AW'(1);
`ifdef RAM_SORT_EARLY_EXIT_EN
          r_swapped <= 1'b0;
`endif
        end
      end
    end
  end

  ram_bus_drv #(.DW(DW)) u_bus (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .wdata (w_wdata),
    .cap_a (w_cap_a),
    .cap_b (w_cap_b),
    .data  (data),
    .a_q   (w_a_q),
    .b_q   (w_b_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_sorter.sv
// ============================================================================
// Module   : tb_ram_sorter
// Brief    : Self-checking bench for ram_sorter with a behavioural 8x8 RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_sorter;

  localparam logic [63:0] INIT_IMG  = 64'h5a193c0f1e4b2d0a; // 90,25,60,15,30,75,45,10
  localparam logic [63:0] INIT_SORT = 64'h0a0f191e2d3c4b5a; // 10,15,25,30,45,60,75,90
  localparam logic [63:0] ASC_1_8   = 64'h0102030405060708;
  localparam logic [63:0] DSC_8_1   = 64'h0807060504030201;
`ifdef RAM_SORT_EARLY_EXIT_EN
  localparam int SORTED_LAT = 22;
`else
  localparam int SORTED_LAT = 85;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] add;
  logic       wr;
  wire  [7:0] data;
  logic       busy;
  logic       done;
  logic [7:0] swap_cnt;

  logic [7:0] mem [8];
  logic       pre_we = 1'b0;
  logic [2:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  int n_pass = 0;
  int n_total = 0;
  int wr_low = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  ram_sorter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .add      (add),
    .wr       (wr),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .swap_cnt (swap_cnt)
  );

  // Behavioural RAM: combinational read when wr=1, store at clk when wr=0.
  assign data = wr ? mem[add] : 8'bz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= INIT_IMG[63-8*i -: 8];
    end else if (!wr) begin
      mem[add] <= data;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  function automatic logic [63:0] mem_img();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[63-8*i -: 8] = mem[i];
    return v;
  endfunction

  // Bus integrity monitor on the falling edge.
  always @(negedge clk) begin
    if (!wr) wr_low++;
    if (done) done_cnt++;
    n_total++;
    if ((wr && (data !== mem[add])) || (!wr && $isunknown(data))) begin
      $display("FAIL bus_integrity: wr=%b add=%0d data=%h ram=%h", wr, add, data, mem[add]);
    end else begin
      n_pass++;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic preload(input logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 3'(i); pre_data = v[63-8*i -: 8];
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Starts a sort; lat = edge number (sampling edge = 1) after which done is first high.
  task automatic run_sort(input bit extra_starts, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      start = extra_starts && (lat == 5 || lat == 40);
    end
    start = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++;
    if ({add, wr, busy, done, swap_cnt} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL reset_state: add=%0d wr=%b busy=%b done=%b swap_cnt=%0d", add, wr, busy, done, swap_cnt);
    end else n_pass++;
    chk("reset_ram", mem_img(), INIT_IMG);
  endtask

  task automatic test_init_image();
    int lat;
    done_cnt = 0;
    run_sort(1'b0, lat);
    chk("init_latency", 64'(lat), 64'd121);
    @(posedge clk); #1;
    chk("init_done_pulse", {62'd0, done, busy}, 64'd0);
    chk("init_swaps", 64'(swap_cnt), 64'd18);
    chk("init_result", mem_img(), INIT_SORT);
    chk("init_done_count", 64'(done_cnt), 64'd1);
  endtask

  task automatic test_sorted();
    int lat;
    preload(ASC_1_8);
    wr_low = 0;
    run_sort(1'b0, lat);
    chk("sorted_latency", 64'(lat), 64'(SORTED_LAT));
    chk("sorted_swaps", 64'(swap_cnt), 64'd0);
    chk("sorted_no_writes", 64'(wr_low), 64'd0);
    chk("sorted_result", mem_img(), ASC_1_8);
  endtask

  task automatic test_reverse();
    int lat;
    preload(DSC_8_1);
    run_sort(1'b0, lat);
    chk("reverse_latency", 64'(lat), 64'd141);
    chk("reverse_swaps", 64'(swap_cnt), 64'd28);
    chk("reverse_result", mem_img(), ASC_1_8);
    repeat (3) @(posedge clk);
    #1 chk("swap_cnt_hold", 64'(swap_cnt), 64'd28);
  endtask

  task automatic test_start_ignored();
    int lat;
    apply_reset();
    done_cnt = 0;
    run_sort(1'b1, lat);
    repeat (4) @(posedge clk);
    #1;
    chk("restart_latency", 64'(lat), 64'd121);
    chk("restart_done_count", 64'(done_cnt), 64'd1);
    chk("restart_swaps", 64'(swap_cnt), 64'd18);
    chk("restart_result", mem_img(), INIT_SORT);
    chk("restart_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic test_mid_reset();
    int lat;
    apply_reset();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (29) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({wr, busy, done, swap_cnt, add} !== {1'b1, 1'b0, 1'b0, 8'd0, 3'd0}) begin
      $display("FAIL mid_reset_outputs: wr=%b busy=%b done=%b swap_cnt=%0d add=%0d", wr, busy, done, swap_cnt, add);
    end else n_pass++;
    chk("mid_reset_ram", mem_img(), INIT_IMG);
    @(posedge clk);
    #1 rst = 1'b0;
    run_sort(1'b0, lat);
    chk("post_reset_latency", 64'(lat), 64'd121);
    chk("post_reset_swaps", 64'(swap_cnt), 64'd18);
    chk("post_reset_result", mem_img(), INIT_SORT);
  endtask

  initial begin
    test_reset();
    test_init_image();
    test_sorted();
    test_reverse();
    test_start_ignored();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
